serial_subtractor_ctrl: RTL and testbench

Bit-serial WIDTH-bit subtractor controller that sequences a single 1-bit full-subtract datapath (two cascaded half-subtractor stages plus borrow OR) over WIDTH clock cycles, LSB first. It sits beside the combinational half-subtractor cells in the arithmetic library. It provides an area-minimal multi-bit A−B with a start/done handshake for slow control paths.

---
 rtl/serial_subtractor_ctrl.sv | 109 ++++++++++
 tb/tb_serial_subtractor_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full-subtract cell (two half-subtract stages
// plus borrow OR) is stepped over the operands LSB first, with a start/done handshake.
module serial_subtractor_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] sd;
   logic [WIDTH-1:0] sd_next;
   logic             bin;
   logic [CW-1:0]    cnt;
   logic             last_bit;
   logic             d1;
   logic             b1;
   logic             dbit;
   logic             b2;

   assign last_bit = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = SHIFT;
         SHIFT:   if (last_bit) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   // One full-subtract step on the current LSBs; the new difference bit enters at the MSB
   // so that after WIDTH steps sd holds the result in natural bit order.
   always_comb begin
      d1      = sa[0] ^ sb[0];
      b1      = ~sa[0] & sb[0];
      dbit    = d1 ^ bin;
      b2      = ~d1 & bin;
      sd_next = sd >> 1;
      sd_next[WIDTH-1] = dbit;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sa  <= '0;
         sb  <= '0;
         sd  <= '0;
         bin <= 1'b0;
         cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sa  <= a;
                  sb  <= b;
                  sd  <= '0;
                  bin <= 1'b0;
                  cnt <= '0;
               end
            end
            SHIFT: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               sd  <= sd_next;
               bin <= b1 | b2;
               cnt <= cnt + CW'(1);
            end
            default: begin
            end
         endcase
      end
   end

   assign diff       = sd;
   assign borrow_out = bin;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed bench for serial_subtractor_ctrl: an 8-bit and a 1-bit instance checked
// against hand-computed vectors plus back-to-back, reset and priority sequences.
module tb_serial_subtractor_ctrl;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] d;
      logic       br;
   } vec8_t;

   typedef struct {
      logic [0:0] a;
      logic [0:0] b;
      logic [0:0] d;
      logic       br;
   } vec1_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start8;
   logic [7:0] a8;
   logic [7:0] b8;
   logic       busy8;
   logic       done8;
   logic [7:0] diff8;
   logic       borrow8;
   logic       start1;
   logic [0:0] a1;
   logic [0:0] b1;
   logic       busy1;
   logic       done1;
   logic [0:0] diff1;
   logic       borrow1;

   int checks   = 0;
   int failures = 0;

   vec8_t v8[4];
   vec1_t v1[4];

   always #5 clk = ~clk;

   serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .rst       (rst),
      .start     (start8),
      .a         (a8),
      .b         (b8),
      .busy      (busy8),
      .done      (done8),
      .diff      (diff8),
      .borrow_out(borrow8)
   );

   serial_subtractor_ctrl #(.WIDTH(1)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .start     (start1),
      .a         (a1),
      .b         (b1),
      .busy      (busy1),
      .done      (done1),
      .diff      (diff1),
      .borrow_out(borrow1)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Launch one 8-bit operation and check latency, result, busy span and hold after done.
   task automatic applyStimulus8(input logic [7:0] av, input logic [7:0] bv,
                                 input logic [7:0] ed, input logic eb);
      int n;
      int busyCnt;
      @(negedge clk);
      a8 = av;
      b8 = bv;
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      n = 0;
      busyCnt = 0;
      while (!done8 && n < 40) begin
         if (busy8) busyCnt++;
         @(negedge clk);
         n++;
      end
      if (busy8) busyCnt++;
      checkOutput("latency8", n, 8);
      checkOutput("diff8", diff8, ed);
      checkOutput("borrow8", borrow8, eb);
      @(negedge clk);
      checkOutput("busy8_after", busy8, 0);
      checkOutput("done8_after", done8, 0);
      checkOutput("diff8_hold", diff8, ed);
      checkOutput("busy8_span", busyCnt, 9);
   endtask

   task automatic applyStimulus1(input logic [0:0] av, input logic [0:0] bv,
                                 input logic [0:0] ed, input logic eb);
      int n;
      int busyCnt;
      @(negedge clk);
      a1 = av;
      b1 = bv;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      n = 0;
      busyCnt = 0;
      while (!done1 && n < 10) begin
         if (busy1) busyCnt++;
         @(negedge clk);
         n++;
      end
      if (busy1) busyCnt++;
      checkOutput("latency1", n, 1);
      checkOutput("diff1", diff1, ed);
      checkOutput("borrow1", borrow1, eb);
      @(negedge clk);
      checkOutput("busy1_after", busy1, 0);
      checkOutput("busy1_span", busyCnt, 2);
   endtask

   initial begin
      int pulses;
      int pulseAt[3];
      int doneCnt;

      v8[0] = '{8'd100, 8'd37,  8'd63,  1'b0};
      v8[1] = '{8'd37,  8'd100, 8'hC1,  1'b1};
      v8[2] = '{8'h00,  8'h01,  8'hFF,  1'b1};
      v8[3] = '{8'hFF,  8'hFF,  8'h00,  1'b0};
      v1[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
      v1[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
      v1[2] = '{1'b0, 1'b1, 1'b1, 1'b1};
      v1[3] = '{1'b1, 1'b1, 1'b0, 1'b0};

      rst = 1'b1;
      start8 = 1'b0;
      start1 = 1'b0;
      a8 = '0;
      b8 = '0;
      a1 = '0;
      b1 = '0;
      repeat (2) @(negedge clk);
      checkOutput("rst_busy", busy8, 0);
      checkOutput("rst_done", done8, 0);
      checkOutput("rst_diff", diff8, 0);
      checkOutput("rst_borrow", borrow8, 0);
      checkOutput("rst_busy1", busy1, 0);
      rst = 1'b0;

      for (int i = 0; i < 4; i++) begin
         applyStimulus8(v8[i].a, v8[i].b, v8[i].d, v8[i].br);
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus1(v1[i].a, v1[i].b, v1[i].d, v1[i].br);
      end

      // start held high: accepted every WIDTH+2 edges; operand changes mid-SHIFT must not leak in
      @(negedge clk);
      a8 = 8'd5;
      b8 = 8'd3;
      start8 = 1'b1;
      @(negedge clk);
      pulses = 0;
      pulseAt[0] = -1;
      pulseAt[1] = -1;
      pulseAt[2] = -1;
      for (int n = 0; n < 29; n++) begin
         if (done8) begin
            checkOutput("b2b_diff", diff8, 2);
            if (pulses < 3) pulseAt[pulses] = n;
            pulses++;
         end
         if (n == 3 || n == 13 || n == 23) begin
            a8 = 8'd200;
            b8 = 8'd1;
         end
         if (n == 8 || n == 18) begin
            a8 = 8'd5;
            b8 = 8'd3;
         end
         @(negedge clk);
      end
      start8 = 1'b0;
      checkOutput("b2b_pulses", pulses, 3);
      checkOutput("b2b_first", pulseAt[0], 8);
      checkOutput("b2b_second", pulseAt[1], 18);
      checkOutput("b2b_third", pulseAt[2], 28);
      @(negedge clk);
      checkOutput("b2b_idle", busy8, 0);

      // Reset on the 4th SHIFT edge aborts the operation without a done pulse
      a8 = 8'd100;
      b8 = 8'd37;
      start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("abort_busy", busy8, 0);
      checkOutput("abort_done", done8, 0);
      checkOutput("abort_diff", diff8, 0);
      checkOutput("abort_borrow", borrow8, 0);
      rst = 1'b0;
      doneCnt = 0;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         if (done8) doneCnt++;
      end
      checkOutput("abort_nodone", doneCnt, 0);
      applyStimulus8(8'd9, 8'd4, 8'd5, 1'b0);

      // rst wins over start on the same IDLE edge
      @(negedge clk);
      rst = 1'b1;
      start8 = 1'b1;
      a8 = 8'd50;
      b8 = 8'd10;
      @(negedge clk);
      checkOutput("prio_busy", busy8, 0);
      checkOutput("prio_diff", diff8, 0);
      rst = 1'b0;
      start8 = 1'b0;
      @(negedge clk);
      checkOutput("prio_busy_next", busy8, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
